imem_loader: RTL and testbench
==============================

# imem_loader

Writable instruction store that replaces the hard-coded instruction ROM in front of the single-cycle CPU's fetch stage. It accepts a program as a byte stream (high byte first) over a valid/ready handshake, assembles 16-bit instruction words into a 16-entry RAM, and holds the CPU in reset while loading. It also serves the combinational fetch port addressed by the CPU's byte-addressed PC.

## Interface
- DEPTH, 16, number of 16-bit instruction words (power of two)
- AW, 4, word-address width, log2(DEPTH)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_req  in  1  one-cycle request to start a program load; sampled only in RUN
- byte_valid  in  1  byte_in carries a valid byte
- byte_in  in  8  program byte, per word: high byte first, then low byte
- byte_ready  out  1  loader accepts a byte this cycle
- pc_in  in  16  CPU byte address; word index = pc_in[AW:1]
- instr_out  out  16  instruction at pc_in, combinational
- cpu_hold  out  1  high while loading; OR'd into the CPU reset at top level
- load_done  out  1  one-cycle pulse on successful load completion
- load_err  out  1  checksum failure flag (see Configuration)
- word_count  out  AW+1  words written in the current or last load

## Operation
- States: RUN, LOAD_HI, LOAD_LO, CHK (macro only), DONE, ERR (macro only).
- Handshake: a byte is accepted on a rising edge with byte_valid & byte_ready. byte_ready = 1 in LOAD_HI, LOAD_LO, CHK, else 0. Gaps in byte_valid are allowed and stall the FSM.
- RUN: cpu_hold = 0. load_req -> LOAD_HI; write pointer := 0, word_count := 0, XOR accumulator := 0, load_err := 0.
- LOAD_HI: accepted byte -> hi register; next LOAD_LO.
- LOAD_LO: accepted byte -> mem[ptr] := {hi, byte}; ptr++, word_count++. If ptr == DEPTH-1 before the increment, go to CHK when the macro is defined, else DONE. Otherwise go to LOAD_HI.
- DONE: load_done = 1 for exactly one cycle; next RUN.
- load_req is ignored outside RUN and ERR.
- cpu_hold = 1 in every state except RUN.
- Fetch: instr_out = mem[pc_in[AW:1]] when pc_in[15:AW+1] == 0, else 16'h0000. This holds in all states, including during a load.
- pc_in[0] is ignored.
- Memory is not written except in LOAD_LO.

## Timing
- Reset (async assert, synchronous deassert at top level):
  - state = RUN
  - all DEPTH words = 16'h0000 (ADD r0,r0,r0)
  - cpu_hold = 0, byte_ready = 0, load_done = 0, load_err = 0, word_count = 0
- load_req at edge N: cpu_hold and byte_ready are high from cycle N+1. The first byte can be accepted at edge N+1.
- A word written at edge M is visible on instr_out from cycle M+1.
- Minimum load time, with no gaps and no macro: 2*DEPTH accepting edges, plus one DONE cycle. cpu_hold falls in the cycle after DONE, and the CPU then fetches from PC 0.
- Reset mid-load: immediate return to RUN with memory cleared. Partially loaded words are lost.
- word_count saturates at DEPTH and holds its value after load until the next load_req.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - Every accepted program byte is XOR'd into an 8-bit accumulator.
  - After the last word, CHK accepts one extra byte.
  - If the byte equals the accumulator, go to DONE.
  - Otherwise go to ERR: load_err = 1, cpu_hold = 1, memory keeps the loaded words.
  - ERR exits only on load_req, which restarts the load and clears load_err, or on reset.
- Not defined: no CHK or ERR states, no accumulator, load_err tied to 0.

## Test plan
- Reset check: assert rst_n = 0 mid-cycle. Response: all outputs at their reset values, and instr_out = 0000 for pc_in = 0, 2, … 30.
- Full load, no gaps: load the 32 bytes 0x01,0x23, 0x12,0x34, … (word k = 16'h0123 + k*16'h1111 mod 2^16). Response: load_done pulses once, word_count = 16, and pc_in = 2k returns word k. With the macro, also send the correct XOR byte.
- Random byte_valid gaps, ~50% duty: same data, identical memory image. cpu_hold stays high throughout and falls exactly one cycle after load_done.
- load_req pulsed during LOAD_LO: ignored, with no restart and word_count continuing. Separately, assert rst_n = 0 after 5 words: state RUN, all words 0000, cpu_hold = 0.
- Out-of-range fetch: pc_in = 16'h0020 or 16'hFFFE returns 0000. pc_in = 16'h0003 returns word 1.
- Macro only, checksum mismatch: send a wrong checksum byte. Response: load_err = 1, cpu_hold stays 1, no load_done pulse. A following load_req plus a correct load clears load_err and releases cpu_hold.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writable instruction store for the single-cycle CPU fetch stage. A program
// arrives as a byte stream (high byte of each word first) over a valid/ready
// handshake and is assembled into DEPTH 16-bit words. The CPU is held in reset
// (cpu_hold) for the whole load. The fetch port is combinational and always
// live, including during a load.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the last word. A mismatch parks the loader in an error
// state with load_err set and the CPU still held. Without the macro there is
// no checksum phase and load_err is tied low.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset (clears state and memory)
//   load_req    one-cycle request to start a load (RUN, or ERR with checksum)
//   byte_valid  byte_in carries a valid byte
//   byte_in     program byte, high byte of each word first
//   byte_ready  loader accepts a byte this cycle
//   pc_in       CPU byte address; word index = pc_in[AW:1], bit 0 ignored
//   instr_out   instruction at pc_in, 0000 when pc_in is beyond the store
//   cpu_hold    high in every state except RUN
//   load_done   one-cycle pulse when a load completes successfully
//   load_err    checksum failure flag
//   word_count  words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          byte_valid,
  input  logic [7:0]    byte_in,
  output logic          byte_ready,
  input  logic [15:0]   pc_in,
  output logic [15:0]   instr_out,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_count
);

  typedef enum logic [2:0] {
    S_RUN,
    S_LOAD_HI,
    S_LOAD_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   word_count_q, word_count_d;
  logic [7:0]    hi_q, hi_d;
  logic          byte_ready_q, byte_ready_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          load_done_q, load_done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    acc_q, acc_d;
  logic          load_err_q, load_err_d;
`endif

  logic          accept;
  logic          start;
  logic          mem_we;
  logic [15:0]   mem_q [DEPTH];

  // pc_in[0] selects a byte within a word; fetch is word-granular.
  logic          pc_lsb_unused;
  assign pc_lsb_unused = pc_in[0];

  assign accept = byte_valid & byte_ready_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign start = load_req & ((state_q == S_RUN) | (state_q == S_ERR));
`else
  assign start = load_req & (state_q == S_RUN);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    hi_d         = hi_q;
    mem_we       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d        = acc_q;
    load_err_d   = load_err_q;
`endif

    if (start) begin
      state_d      = S_LOAD_HI;
      ptr_d        = '0;
      word_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_d        = '0;
      load_err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_RUN: state_d = S_RUN;

        S_LOAD_HI: begin
          if (accept) begin
            hi_d    = byte_in;
            state_d = S_LOAD_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_d   = acc_q ^ byte_in;
`endif
          end
        end

        S_LOAD_LO: begin
          if (accept) begin
            mem_we       = 1'b1;
            ptr_d        = ptr_q + AW'(1);
            word_count_d = word_count_q + (AW+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_d        = acc_q ^ byte_in;
`endif
            // The pointer wraps to 0 after the last word; word_count reaches
            // exactly DEPTH and stops there because no further word is taken.
            if (ptr_q == AW'(DEPTH - 1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_LOAD_HI;
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            if (byte_in == acc_q) begin
              state_d = S_DONE;
            end else begin
              state_d    = S_ERR;
              load_err_d = 1'b1;
            end
          end
        end

        // Only a new load_req (handled by start) or reset leaves ERR.
        S_ERR: state_d = S_ERR;
`endif

        S_DONE: state_d = S_RUN;

        default: state_d = S_RUN;
      endcase
    end

    // Outputs are registered: derive them from the state being entered.
    byte_ready_d = (state_d == S_LOAD_HI) | (state_d == S_LOAD_LO) |
                   (state_d == S_CHK);
    cpu_hold_d   = (state_d != S_RUN);
    load_done_d  = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      ptr_q        <= '0;
      word_count_q <= '0;
      hi_q         <= '0;
      byte_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q        <= '0;
      load_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      hi_q         <= hi_d;
      byte_ready_q <= byte_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q        <= acc_d;
      load_err_q   <= load_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction store
  // ---------------------------------------------------------------------------
  // NOTE: the store is built from resettable flops, not a RAM macro, because
  // reset must return every word to 0000 (ADD r0,r0,r0) in one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[ptr_q] <= {hi_q, byte_in};
    end
  end

  // Fetch port: anything past the last word reads as 0000.
  assign instr_out  = (pc_in[15:AW+1] == '0) ? mem_q[pc_in[AW:1]] : 16'h0000;

  assign byte_ready = byte_ready_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign word_count = word_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign load_err   = load_err_q;
`else
  assign load_err   = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A behavioural model tracks the loader
// as "how many program bytes have arrived" plus a few flags and a word array;
// a compare process checks every DUT output against it on each falling edge.
// Literal expectations pin the model at key points. Define
// IMEM_LOADER_CHECKSUM_EN for both DUT and bench to test the checksum build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_req = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic [15:0]   pc_in = 16'h0000;
  logic          byte_ready;
  logic [15:0]   instr_out;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .pc_in      (pc_in),
    .instr_out  (instr_out),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int n_done_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: byte counter, flags and a word array
  // ---------------------------------------------------------------------------
  logic [15:0] m_mem [DEPTH];
  bit          m_loading;   // loader wants bytes (program or checksum)
  bit          m_done;      // completion cycle
  bit          m_err;       // checksum failed, waiting for a new load
  int          m_nbytes;    // program bytes received in this load
  logic [7:0]  m_hi;
  logic [7:0]  m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
      m_loading = 0; m_done = 0; m_err = 0; m_nbytes = 0;
      m_hi = 8'h00; m_acc = 8'h00;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_loading) begin
      if (byte_valid) begin
        if (m_nbytes < 2*DEPTH) begin
          if (m_nbytes % 2 == 0) m_hi = byte_in;
          else m_mem[m_nbytes/2] = {m_hi, byte_in};
          m_acc = m_acc ^ byte_in;
          m_nbytes++;
          if (m_nbytes == 2*DEPTH && !CHK_EN) begin
            m_loading = 0; m_done = 1;
          end
        end else begin
          m_loading = 0;
          if (byte_in == m_acc) m_done = 1;
          else m_err = 1;
        end
      end
    end else if (load_req) begin
      m_loading = 1; m_nbytes = 0; m_acc = 8'h00; m_err = 0;
    end
  end

  function automatic logic [15:0] exp_instr(input logic [15:0] pc);
    if (pc[15:AW+1] != 0) return 16'h0000;
    return m_mem[pc[AW:1]];
  endfunction

  always @(negedge clk) begin
    if (load_done === 1'b1) n_done_pulses++;
    if (chk_on) begin
      check("byte_ready", 32'(byte_ready), 32'(m_loading));
      check("cpu_hold",   32'(cpu_hold),   32'(m_loading | m_done | m_err));
      check("load_done",  32'(load_done),  32'(m_done));
      check("load_err",   32'(load_err),   32'(m_err));
      check("word_count", 32'(word_count), 32'(m_nbytes / 2));
      check("instr_out",  32'(instr_out),  32'(exp_instr(pc_in)));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_pc();
    if ($urandom_range(3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 35));
  endfunction

  task automatic do_reset();
    #3 rst_n = 1'b0;          // mid-cycle assertion
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // chk_mode: 0 = no checksum byte, 1 = correct, 2 = wrong
  function automatic void make_prog(output logic [7:0] q[$], input bit rand_data,
                                    input int chk_mode);
    logic [7:0]  acc;
    logic [15:0] w;
    acc = 8'h00;
    q = {};
    for (int k = 0; k < DEPTH; k++) begin
      w = rand_data ? 16'($urandom) : 16'h0123 + 16'(k) * 16'h1111;
      q.push_back(w[15:8]);
      q.push_back(w[7:0]);
      acc = acc ^ w[15:8] ^ w[7:0];
    end
    if (chk_mode == 1) q.push_back(acc);
    else if (chk_mode == 2) q.push_back(acc ^ 8'h5A);
  endfunction

  // Sends bytes with byte_valid duty cycle 'duty' percent; pulses load_req
  // alongside byte number req_at (-1 for never).
  task automatic send_bytes(input logic [7:0] bytes[$], input int duty, input int req_at);
    for (int i = 0; i < bytes.size(); i++) begin
      int  guard;
      bit  taken;
      guard = 0;
      taken = 0;
      while (!taken) begin
        byte_in    = bytes[i];
        byte_valid = ($urandom_range(99) < duty);
        load_req   = (i == req_at) && (guard == 0);
        taken      = byte_valid && byte_ready;
        tick();
        load_req   = 1'b0;
        pc_in      = rand_pc();
        guard++;
        if (!taken && guard > 100) begin
          n_checks++; n_fail++;
          $display("FAIL byte_accept_timeout: byte %0d not accepted after %0d cycles", i, guard);
          byte_valid = 1'b0;
          return;
        end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    while (cpu_hold !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL %s: cpu_hold=%b after %0d cycles, required 0", name, cpu_hold, n);
    end
  endtask

  task automatic fetch_check(input string name, input logic [15:0] pc, input logic [15:0] exp);
    pc_in = pc;
    @(negedge clk);
    check(name, 32'(instr_out), 32'(exp));
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] prog[$];
    int         pulses0;
    int         good_chk;

    good_chk = CHK_EN ? 1 : 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    tick();
    do_reset();
    @(negedge clk);
    check("rst_cpu_hold",   32'(cpu_hold),   0);
    check("rst_byte_ready", 32'(byte_ready), 0);
    check("rst_load_done",  32'(load_done),  0);
    check("rst_load_err",   32'(load_err),   0);
    check("rst_word_count", 32'(word_count), 0);
    tick();
    for (int k = 0; k < DEPTH; k++) fetch_check("rst_instr", 16'(2*k), 16'h0000);

    // Full load, no gaps
    pulses0 = n_done_pulses;
    make_prog(prog, 1'b0, good_chk);
    pulse_load_req();
    send_bytes(prog, 100, -1);
    wait_release("full_load_release");
    check("full_done_pulses", 32'(n_done_pulses - pulses0), 1);
    check("full_word_count",  32'(word_count), 16);
    fetch_check("fetch_pc0",    16'h0000, 16'h0123);
    fetch_check("fetch_pc2",    16'h0002, 16'h1234);
    fetch_check("fetch_pc3",    16'h0003, 16'h1234);
    fetch_check("fetch_pc30",   16'h001E, 16'h0122);
    fetch_check("fetch_pc20h",  16'h0020, 16'h0000);
    fetch_check("fetch_pcFFFE", 16'hFFFE, 16'h0000);

    // Same data with ~50% byte_valid gaps after clearing memory
    do_reset();
    tick();
    pulses0 = n_done_pulses;
    pulse_load_req();
    send_bytes(prog, 50, -1);
    wait_release("gap_load_release");
    check("gap_done_pulses", 32'(n_done_pulses - pulses0), 1);
    fetch_check("gap_fetch_pc10", 16'h000A, 16'h5678);
    fetch_check("gap_fetch_pc30", 16'h001E, 16'h0122);

    // load_req pulsed while waiting for a low byte: must be ignored
    pulses0 = n_done_pulses;
    make_prog(prog, 1'b1, good_chk);
    pulse_load_req();
    send_bytes(prog, 70, 7);
    wait_release("req_in_lo_release");
    check("req_in_lo_word_count",  32'(word_count), 16);
    check("req_in_lo_done_pulses", 32'(n_done_pulses - pulses0), 1);

    // Reset after 5 words
    make_prog(prog, 1'b1, 0);
    prog = prog[0:9];
    pulse_load_req();
    send_bytes(prog, 100, -1);
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cpu_hold",   32'(cpu_hold),   0);
    check("midrst_word_count", 32'(word_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < DEPTH; k++) fetch_check("midrst_instr", 16'(2*k), 16'h0000);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: ERR, then recover with a correct load
    pulses0 = n_done_pulses;
    make_prog(prog, 1'b0, 2);
    pulse_load_req();
    send_bytes(prog, 100, -1);
    repeat (5) tick();
    @(negedge clk);
    check("bad_chk_load_err",    32'(load_err), 1);
    check("bad_chk_cpu_hold",    32'(cpu_hold), 1);
    check("bad_chk_done_pulses", 32'(n_done_pulses - pulses0), 0);
    tick();
    fetch_check("bad_chk_mem_kept", 16'h0002, 16'h1234);
    make_prog(prog, 1'b0, 1);
    pulse_load_req();
    send_bytes(prog, 60, -1);
    wait_release("recover_release");
    check("recover_load_err", 32'(load_err), 0);
`endif

    // Randomized loads with random gaps and stray load_req pulses
    for (int r = 0; r < 4; r++) begin
      make_prog(prog, 1'b1, good_chk);
      pulse_load_req();
      send_bytes(prog, $urandom_range(30, 100), $urandom_range(0, 2*DEPTH - 1));
      wait_release("rand_load_release");
      repeat (20) begin
        pc_in = rand_pc();
        load_req = ($urandom_range(7) == 0) && (r == 3);
        tick();
        load_req = 1'b0;
        // A stray request in the last round starts a load; finish it off.
        if (cpu_hold === 1'b1) begin
          make_prog(prog, 1'b1, good_chk);
          send_bytes(prog, 80, -1);
          wait_release("stray_load_release");
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
